conv_map_collector: RTL and testbench
=====================================

# conv_map_collector

Receiving end of the convolution adder output stream. Captures each `wr`-qualified 16-bit saturated sum into an on-chip feature-map buffer of `NUM_OUT` words, with optional ReLU on capture. Signals the next layer when a complete map is held, serves random-access reads, and re-arms when the next layer releases the map. Sits between a conv adder stage and the following pooling/conv layer.

## Interface
- `DATA_W`, 16, sample width (signed two's complement)
- `NUM_OUT`, 324, words per output map
- `ADDR_W`, 9, buffer address width; must satisfy 2^ADDR_W ≥ NUM_OUT
- `clk_in`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr`  in  1  one-cycle strobe: `din` valid this cycle
- `din`  in  DATA_W  signed sample from adder stage
- `relu_en`  in  1  1 = clamp negative samples to 0 on capture
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_W  read word index
- `rd_data`  out  DATA_W  read result, registered
- `rd_valid`  out  1  `rd_data` valid strobe
- `map_ready`  out  1  complete map held, readable
- `release`  in  1  consumer finished with map; re-arm
- `wr_count`  out  ADDR_W  words captured in current map
- `overflow`  out  1  sticky: a `wr` arrived while `map_ready`

## Operation
- Reset (async assert, sync release): state FILL, `wr_count`=0, `rd_data`=0, `rd_valid`=0, `map_ready`=0, `overflow`=0. Buffer contents undefined.
- State FILL:
  - `wr`=1: store f(`din`) at address `wr_count`, then `wr_count`+1.
  - f(x) = 0 when `relu_en`=1 and x<0; otherwise x unchanged. No width change.
  - Write with `wr_count`=NUM_OUT-1: word stored, `wr_count`→NUM_OUT, state→FULL, `map_ready`=1 next cycle.
  - `release` ignored.
- State FULL:
  - `wr`=1: sample dropped, `overflow` set; it stays set until reset.
  - `release`=1: state→FILL, `wr_count`→0, `map_ready`→0 next cycle.
  - `wr` in the same cycle as `release` is dropped and sets `overflow`.
  - The first accepted write is the one on the cycle after `release`.
- Reads are legal in both states:
  - `rd_en`=1 with `rd_addr`<NUM_OUT: `rd_data`=buffer[`rd_addr`] next cycle, `rd_valid`=1.
  - `rd_addr`≥NUM_OUT: `rd_data`=0, `rd_valid`=1.
  - `rd_en`=0: `rd_valid`=0 and `rd_data` holds its last value.
- Same-address read and write in one cycle returns the old contents (read-first).

## Timing
- Write acceptance: zero-bubble; `wr` may be high every cycle.
- Capture latency: sample on `wr` at cycle N is readable by a `rd_en` at cycle N+1 (data at N+2).
- `map_ready` rises 1 cycle after the final accepted `wr`; falls 1 cycle after `release`.
- `wr_count` updates 1 cycle after each accepted `wr`.
- Read latency: exactly 1 cycle; fully pipelined, one read per cycle.
- Reset asserted mid-fill: the partial map is discarded and all outputs return to reset values immediately.

## Structure
- The shared conv package holds:
  - `DATA_W`
  - the FILL/FULL state encoding
  - the saturation constants 16'sh7FFF and 16'sh8000 (also used by the adder stages).
- One sub-module, `map_ram`: simple dual-port synchronous RAM with one write port, one read port, read-first behaviour and registered output, inferable as block RAM.
- FSM, counter, ReLU and flags stay in the top level.

## Test plan
- Fill: 324 `wr` pulses with `din`=i (i=0..323), `relu_en`=0.
  - Required: `map_ready` rises exactly 1 cycle after the 324th pulse.
  - Required: reads of addresses 0, 17 and 323 return 0, 17 and 323 with 1-cycle latency.
- ReLU: `relu_en`=1, `din` sequence -32768, -1, 0, 32767 at addresses 0–3.
  - Required: readback 0, 0, 0, 32767.
- Overflow:
  - Continue with 2 extra `wr` after full. Required: `overflow`=1, buffer[0] unchanged, `wr_count`=324.
  - Pulse `release` together with a `wr`. Required: that sample is dropped, `wr_count`=0, `map_ready`=0.
- Back-to-back and spaced strobes: `wr` pulsed every 25 cycles (adder cadence) versus every cycle.
  - Required: identical buffer contents and identical `map_ready` timing relative to the last pulse.
- Reads at boundaries:
  - `rd_addr`=324 and 511: required `rd_data`=0, `rd_valid`=1.
  - Same-address read and write: required old data returned.
- Async reset at `wr_count`=100 mid-fill. Required:
  - immediate `map_ready`=0, `wr_count`=0, `rd_valid`=0, `overflow`=0;
  - a subsequent full fill behaves as in the Fill scenario.

Source files
------------

// File: rtl/conv_map_collector_pkg.sv
// Shared conv-pipeline definitions: sample width,
// map-collector state encoding and saturation limits.
package conv_map_collector_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN =
    16'sh8000;

  function automatic logic [DATA_W-1:0] relu(
    input logic [DATA_W-1:0] x,
    input logic              en
  );
    return (en && x[DATA_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/conv_map_collector_if.sv
// Bundle between the adder stage / next layer
// and the feature-map collector.
interface conv_map_collector_if #(
  parameter int ADDR_W = 9
) ();
  import conv_map_collector_pkg::*;

  logic              wr;
  logic [DATA_W-1:0] din;
  logic              relu_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              map_ready;
  logic              map_release;
  logic [ADDR_W-1:0] wr_count;
  logic              overflow;

  modport master (
    output wr, din, relu_en,
    output rd_en, rd_addr, map_release,
    input  rd_data, rd_valid, map_ready,
    input  wr_count, overflow
  );

  modport slave (
    input  wr, din, relu_en,
    input  rd_en, rd_addr, map_release,
    output rd_data, rd_valid, map_ready,
    output wr_count, overflow
  );

endinterface

// File: rtl/conv_map_collector_map_ram.sv
// Simple dual-port RAM, read-first, registered
// output; no reset so it maps onto block RAM.
module map_ram #(
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 324
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[wa] <= wd;
    if (re) q <= r_mem[ra];
  end

endmodule

// File: rtl/conv_map_collector.sv
// Captures one output feature map from the adder
// stream and serves it to the next layer.
module conv_map_collector
  import conv_map_collector_pkg::*;
#(
  parameter int NUM_OUT = 324,
  parameter int ADDR_W  = 9
) (
  input logic                 clk_in,
  input logic                 rst_n,
  conv_map_collector_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_OUT - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_count;
  logic              r_map_ready;
  logic              r_overflow;
  logic              r_rd_valid;
  logic              r_rd_zero;

  logic              w_we;
  logic              w_rd_hit;
  logic [DATA_W-1:0] w_wd;
  logic [DATA_W-1:0] w_q;

  assign w_we     = bus.wr && (r_state == FILL);
  assign w_rd_hit = bus.rd_en && (bus.rd_addr <= LAST);
  assign w_wd     = relu(bus.din, bus.relu_en);

  map_ram #(
    .DW    (DATA_W),
    .AW    (ADDR_W),
    .DEPTH (NUM_OUT)
  ) u_ram (
    .clk (clk_in),
    .we  (w_we),
    .wa  (r_wr_count),
    .wd  (w_wd),
    .re  (w_rd_hit),
    .ra  (bus.rd_addr),
    .q   (w_q)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_wr_count  <= '0;
      r_map_ready <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (bus.wr) begin
            r_wr_count <= r_wr_count + 1'b1;
            if (r_wr_count == LAST) begin
              r_state     <= FULL;
              r_map_ready <= 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.wr) r_overflow <= 1'b1;
          if (bus.map_release) begin
            r_state     <= FILL;
            r_wr_count  <= '0;
            r_map_ready <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // RAM output is not reset; this flag masks it
  // after reset and for out-of-range reads.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_zero <= !w_rd_hit;
    end
  end

  assign bus.rd_data   = r_rd_zero ? '0 : w_q;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.map_ready = r_map_ready;
  assign bus.wr_count  = r_wr_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_conv_map_collector.sv
// Scoreboard bench for conv_map_collector:
// directed fills, ReLU, overflow, boundary reads.
module tb_conv_map_collector;
  import conv_map_collector_pkg::*;

  localparam int N = 324;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_map_collector_if #(.ADDR_W(9)) bus ();

  conv_map_collector #(
    .NUM_OUT (N),
    .ADDR_W  (9)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string name;
    int    exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(
    input string name,
    input int    act,
    input int    exp
  );
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input int d, input logic re);
    bus.wr      = 1'b1;
    bus.din     = 16'(d);
    bus.relu_en = re;
    tick();
    bus.wr      = 1'b0;
    bus.relu_en = 1'b0;
  endtask

  task automatic rd1(
    input int    a,
    input int    exp,
    input string nm
  );
    rd_exp_t e;
    e.name = nm;
    e.exp  = exp;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 9'(a);
    sb.push_back(e);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic fill(input int gap, input string tag);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1)
        chk({tag, "_ready_early"},
            int'(bus.map_ready), 0);
      wr1(i, 1'b0);
      if (i == 0)
        chk({tag, "_cnt1"}, int'(bus.wr_count), 1);
      if (i < N - 1)
        repeat (gap - 1) tick();
    end
    chk({tag, "_ready"}, int'(bus.map_ready), 1);
    chk({tag, "_cnt"}, int'(bus.wr_count), N);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++)
      tick();
    chk("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (bus.rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        chk(e.name, int'($signed(bus.rd_data)),
            e.exp);
      end
    end
  end

  initial begin
    bus.wr          = 1'b0;
    bus.din         = '0;
    bus.relu_en     = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    bus.map_release = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.map_ready), 0);
    chk("rst_cnt", int'(bus.wr_count), 0);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_data", int'(bus.rd_data), 0);
    rst_n = 1'b1;
    tick();

    fill(1, "b2b");
    rd1(0, 0, "rd0");
    rd1(17, 17, "rd17");
    rd1(323, 323, "rd323");
    tick();
    chk("hold_valid", int'(bus.rd_valid), 0);
    chk("hold_data", int'(bus.rd_data), 323);
    rd1(324, 0, "rd324");
    rd1(511, 0, "rd511");
    drain();

    wr1(999, 1'b0);
    wr1(999, 1'b0);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_cnt", int'(bus.wr_count), N);
    chk("ovf_ready", int'(bus.map_ready), 1);
    rd1(0, 0, "ovf_rd0");
    drain();

    bus.map_release = 1'b1;
    wr1(555, 1'b0);
    bus.map_release = 1'b0;
    chk("rel_cnt", int'(bus.wr_count), 0);
    chk("rel_ready", int'(bus.map_ready), 0);
    chk("rel_ovf", int'(bus.overflow), 1);

    wr1(-32768, 1'b1);
    wr1(-1, 1'b1);
    wr1(0, 1'b1);
    wr1(32767, 1'b1);
    rd1(0, 0, "relu0");
    rd1(1, 0, "relu1");
    rd1(2, 0, "relu2");
    rd1(3, 32767, "relu3");

    // address 4 still holds 4 from the first fill
    bus.wr      = 1'b1;
    bus.din     = 16'd1234;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 9'd4;
    sb.push_back('{"rf_old", 4});
    tick();
    bus.wr    = 1'b0;
    bus.rd_en = 1'b0;
    rd1(4, 1234, "rf_new");
    wr1(-5, 1'b0);
    rd1(5, -5, "neg_norelu");
    drain();

    for (int i = 6; i < 100; i++) wr1(i, 1'b0);
    chk("mid_cnt", int'(bus.wr_count), 100);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 9'd3;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    chk("pre_rst_valid", int'(bus.rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", int'(bus.map_ready), 0);
    chk("arst_cnt", int'(bus.wr_count), 0);
    chk("arst_valid", int'(bus.rd_valid), 0);
    chk("arst_ovf", int'(bus.overflow), 0);
    chk("arst_data", int'(bus.rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    fill(25, "spaced");
    for (int i = 0; i < N; i++)
      rd1(i, i, $sformatf("sweep%0d", i));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
